// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module ex_muldiv #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_ex_muldiv_i,
   input  logic              is_muldiv_ex_muldiv_i,
   input  logic [2:0]        funct3_ex_muldiv_i,
   input  logic [DATA_W-1:0] op1_ex_muldiv_i,
   input  logic [DATA_W-1:0] op2_ex_muldiv_i,
   input  logic              kill_ex_muldiv_i,
   output logic              stall_ex_muldiv_o,
   output logic              done_ex_muldiv_o,
   output logic [DATA_W-1:0] result_ex_muldiv_o
);

   localparam int W2 = 2 * DATA_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W2-1:0]     acc_q, acc_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              done_q, done_d;

   logic              start_s;
   logic              sa_s, sb_s;
   logic              div_zero_s, ovf_s, last_s;
   logic [DATA_W:0]   mul_sum_s;
   logic [W2-1:0]     acc_mul_s, prod_s;
   logic [DATA_W:0]   rem_sh_s, diff_s;
   logic [W2-1:0]     acc_div_s;
   logic [DATA_W-1:0] mul_res_s, div_res_s;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
      return neg ? (~v + DATA_W'(1)) : v;
   endfunction

   assign start_s = valid_ex_muldiv_i & is_muldiv_ex_muldiv_i & ~kill_ex_muldiv_i & (state_q == S_IDLE);

   // Operand signedness: MULH signs both, MULHSU only op1; DIV/REM sign both, unsigned forms none.
   assign sa_s = funct3_ex_muldiv_i[2] ? (~funct3_ex_muldiv_i[0] & op1_ex_muldiv_i[DATA_W-1])
                                       : ((funct3_ex_muldiv_i[1] ^ funct3_ex_muldiv_i[0]) & op1_ex_muldiv_i[DATA_W-1]);
   assign sb_s = funct3_ex_muldiv_i[2] ? (~funct3_ex_muldiv_i[0] & op2_ex_muldiv_i[DATA_W-1])
                                       : ((funct3_ex_muldiv_i[1:0] == 2'b01) & op2_ex_muldiv_i[DATA_W-1]);

   assign div_zero_s = (op2_ex_muldiv_i == {DATA_W{1'b0}});
   assign ovf_s      = ~funct3_ex_muldiv_i[0]
                       & (op1_ex_muldiv_i == {1'b1, {(DATA_W-1){1'b0}}})
                       & (op2_ex_muldiv_i == {DATA_W{1'b1}});
   assign last_s     = (cnt_q == CNT_W'(DATA_W - 1));

   assign mul_sum_s = {1'b0, acc_q[W2-1:DATA_W]} + (opa_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
   assign acc_mul_s = {mul_sum_s, acc_q[DATA_W-1:1]};
   assign prod_s    = neg_q ? (~acc_mul_s + W2'(1)) : acc_mul_s;
   assign mul_res_s = (f3_q[1:0] == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[W2-1:DATA_W];

   // Restoring step: remainder in the upper half, dividend shifts out / quotient shifts in below.
   assign rem_sh_s  = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
   assign diff_s    = rem_sh_s - {1'b0, opb_q};
   assign acc_div_s = diff_s[DATA_W] ? {rem_sh_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                     : {diff_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
   assign div_res_s = f3_q[1] ? mag(acc_div_s[W2-1:DATA_W], rneg_q) : mag(acc_div_s[DATA_W-1:0], neg_q);

   // Next-state and datapath update; kill overrides everything but reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      res_d   = res_q;
      done_d  = 1'b0;
      if (kill_ex_muldiv_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_s) begin
                  f3_d = funct3_ex_muldiv_i;
                  cnt_d = {CNT_W{1'b0}};
                  neg_d = sa_s ^ sb_s;
                  rneg_d = sa_s;
                  opb_d = mag(op2_ex_muldiv_i, sb_s);
                  if (!funct3_ex_muldiv_i[2]) begin
                     state_d = S_MUL;
                     opa_d = mag(op1_ex_muldiv_i, sa_s);
                     acc_d = {W2{1'b0}};
                  end else if (div_zero_s) begin
                     state_d = S_DONE;
                     done_d = 1'b1;
                     res_d = funct3_ex_muldiv_i[1] ? op1_ex_muldiv_i : {DATA_W{1'b1}};
                  end else if (ovf_s) begin
                     state_d = S_DONE;
                     done_d = 1'b1;
                     res_d = funct3_ex_muldiv_i[1] ? {DATA_W{1'b0}} : op1_ex_muldiv_i;
                  end else begin
                     state_d = S_DIV;
                     acc_d = {{DATA_W{1'b0}}, mag(op1_ex_muldiv_i, sa_s)};
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MUL: begin
               acc_d = acc_mul_s;
               opa_d = {1'b0, opa_q[DATA_W-1:1]};
               cnt_d = cnt_q + CNT_W'(1);
               if (last_s) begin
                  state_d = S_DONE;
                  done_d = 1'b1;
                  res_d = mul_res_s;
               end else begin
                  state_d = S_MUL;
               end
            end
            S_DIV: begin
               acc_d = acc_div_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_s) begin
                  state_d = S_DONE;
                  done_d = 1'b1;
                  res_d = div_res_s;
               end else begin
                  state_d = S_DIV;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         acc_q   <= {W2{1'b0}};
         opa_q   <= {DATA_W{1'b0}};
         opb_q   <= {DATA_W{1'b0}};
         f3_q    <= 3'd0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= {DATA_W{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign stall_ex_muldiv_o  = start_s | (state_q == S_MUL) | (state_q == S_DIV);
   assign done_ex_muldiv_o   = done_q;
   assign result_ex_muldiv_o = res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed, table-driven bench for ex_muldiv with hand-written kill, reset and back-to-back sequences.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid, is_md, kill;
   logic [2:0]  f3;
   logic [31:0] op1, op2;
   logic        stall, done;
   logic [31:0] result;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   always #5 clk = ~clk;

   ex_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .valid_ex_muldiv_i     (valid),
      .is_muldiv_ex_muldiv_i (is_md),
      .funct3_ex_muldiv_i    (f3),
      .op1_ex_muldiv_i       (op1),
      .op2_ex_muldiv_i       (op2),
      .kill_ex_muldiv_i      (kill),
      .stall_ex_muldiv_o     (stall),
      .done_ex_muldiv_o      (done),
      .result_ex_muldiv_o    (result)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1;
      is_md = 1'b1;
      f3    = f;
      op1   = a;
      op2   = b;
   endtask

   // Called in the start cycle; returns at the negedge where done is seen (or on timeout).
   task automatic finish_op(input string name, input logic [31:0] exp, input int lat);
      int cycles;
      int stalls;
      #1;
      chk({name, "_start_stall"}, 32'(stall), 32'd1);
      @(negedge clk);
      valid = 1'b0;
      f3    = 3'($urandom_range(0, 7));
      op1   = $urandom;
      op2   = $urandom;
      cycles = 1;
      stalls = 1;
      while (!done && cycles < 100) begin
         if (stall) stalls++;
         @(negedge clk);
         cycles++;
      end
      chk({name, "_latency"}, 32'(cycles), 32'(lat));
      chk({name, "_stall_cycles"}, 32'(stalls), 32'(lat));
      chk({name, "_stall_at_done"}, 32'(stall), 32'd0);
      chk({name, "_result"}, result, exp);
   endtask

   initial begin
      int   k;
      logic saw_done;
      logic [31:0] prev;

      vecs[0]  = '{"mul",        3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{"mulh",       3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 33};
      vecs[2]  = '{"mulhsu",     3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33};
      vecs[3]  = '{"mulhu",      3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vecs[4]  = '{"div",        3'd4, 32'd20,         32'hFFFFFFFD, 32'hFFFFFFFA, 33};
      vecs[5]  = '{"rem",        3'd6, 32'd20,         32'hFFFFFFFD, 32'd2,        33};
      vecs[6]  = '{"divu",       3'd5, 32'd100,        32'd7,        32'd14,       33};
      vecs[7]  = '{"remu",       3'd7, 32'd100,        32'd7,        32'd2,        33};
      vecs[8]  = '{"divu_zero",  3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{"rem_zero",   3'd6, 32'd5,          32'd0,        32'd5,        1};
      vecs[10] = '{"div_ovf",    3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{"rem_ovf",    3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
      vecs[12] = '{"div_neg",    3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
      vecs[13] = '{"rem_neg",    3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
      vecs[14] = '{"mulhsu_big", 3'd2, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};
      vecs[15] = '{"divu_big",   3'd5, 32'h80000000,   32'hFFFFFFFF, 32'd0,        33};
      vecs[16] = '{"remu_big",   3'd7, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};
      vecs[17] = '{"div_zero_s", 3'd4, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 1};

      reset = 1'b1;
      valid = 1'b0;
      is_md = 1'b0;
      kill  = 1'b0;
      f3    = 3'd0;
      op1   = 32'd0;
      op2   = 32'd0;
      #12;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'd0);
      #10 reset = 1'b0;

      // Idle with valid but not a muldiv op: nothing happens.
      @(negedge clk);
      valid = 1'b1;
      is_md = 1'b0;
      #1 chk("not_muldiv_stall", 32'(stall), 32'd0);
      @(negedge clk);
      chk("not_muldiv_done", 32'(done), 32'd0);
      valid = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive_start(vecs[i].f3, vecs[i].a, vecs[i].b);
         finish_op(vecs[i].name, vecs[i].exp, vecs[i].lat);
         @(negedge clk);
         chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      end

      // Kill ten cycles into a divide.
      prev = result;
      @(negedge clk);
      drive_start(3'd5, 32'd1000, 32'd3);
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_stall", 32'(stall), 32'd0);
      chk("kill_done", 32'(done), 32'd0);
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("kill_no_done", 32'(saw_done), 32'd0);
      chk("kill_result_held", result, prev);

      // Kill coincident with start.
      @(negedge clk);
      drive_start(3'd4, 32'd50, 32'd5);
      kill = 1'b1;
      #1 chk("kill_start_stall", 32'(stall), 32'd0);
      @(negedge clk);
      valid = 1'b0;
      kill  = 1'b0;
      chk("kill_start_stall_next", 32'(stall), 32'd0);
      chk("kill_start_done", 32'(done), 32'd0);

      // Asynchronous reset five cycles into a multiply.
      @(negedge clk);
      drive_start(3'd0, 32'd3, 32'd5);
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("areset_stall", 32'(stall), 32'd0);
      chk("areset_done", 32'(done), 32'd0);
      chk("areset_result", result, 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || stall) saw_done = 1'b1;
      end
      chk("areset_quiet", 32'(saw_done), 32'd0);

      // Back-to-back: next op presented in the DONE cycle starts one cycle later.
      @(negedge clk);
      drive_start(3'd0, 32'd7, 32'd6);
      finish_op("b2b_mul", 32'd42, 33);
      drive_start(3'd4, 32'hFFFFFF9C, 32'd7);
      #1 chk("b2b_no_start_in_done", 32'(stall), 32'd0);
      @(negedge clk);
      chk("b2b_done_dropped", 32'(done), 32'd0);
      finish_op("b2b_div", 32'hFFFFFFF2, 33);
      @(negedge clk);
      chk("b2b_done_pulse", 32'(done), 32'd0);

      k = total_cnt;
      if (k == 0) $display("FAIL no_checks: got 0 expected >0");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the operands and funct3 presented by the issue-execute pipeline register, after operand forwarding.
- While an operation is in flight it stalls the issue-execute register and everything upstream of it.
- On completion it presents a 32-bit result to the execute-stage writeback mux (wb_sel path) for exactly one cycle.

Parameters:
DATA_W, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces all state to its reset value immediately
valid_ex_muldiv_i  in  1  execute-stage instruction is valid
is_muldiv_ex_muldiv_i  in  1  decoder flag: op=0110011 and funct7=0000001
funct3_ex_muldiv_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_ex_muldiv_i  in  32  rs1 value after forwarding
op2_ex_muldiv_i  in  32  rs2 value after forwarding
kill_ex_muldiv_i  in  1  flush of the execute stage, same cycle as the issue-execute clr
stall_ex_muldiv_o  out  1  hold issue-execute register and upstream stages
done_ex_muldiv_o  out  1  result_ex_muldiv_o valid this cycle
result_ex_muldiv_o  out  32  RV32M result

Behaviour:
- start = valid & is_muldiv & ~kill & (state==IDLE).
- FSM states are IDLE, MUL, DIV, DONE.
- Reset values: state=IDLE, counter=0, result=0, done=0, stall=0; all internal accumulators are 0.
- Reset asserted mid-operation aborts the operation immediately; no done pulse follows.
- stall_ex_muldiv_o is combinational: start | (state==MUL) | (state==DIV). It is 0 in IDLE and DONE.
- done_ex_muldiv_o = (state==DONE). result_ex_muldiv_o is registered and holds its last value until the next completion.
- IDLE -> MUL when start and funct3[2]=0. Latch |op1| and |op2| according to the signedness:
  - MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MUL and MULHU: both unsigned magnitudes; a signed fixup is still correct for MUL low bits.
  - Latch the product sign and clear the 64-bit accumulator.
- MUL state: 32 shift-add iterations, one multiplier bit per cycle; counter runs 0..31.
  - On counter==31, go to DONE.
  - Apply two's-complement negate on the 64-bit product if the sign is negative.
  - result = product[31:0] for MUL, product[63:32] for MULH, MULHSU and MULHU.
- IDLE -> DIV when start, funct3[2]=1, op2!=0 and not the signed-overflow case.
  - DIV/REM latch magnitudes and track quotient sign (op1 sign XOR op2 sign) and remainder sign (op1 sign).
  - DIVU/REMU use raw values.
- DIV state: 32 restoring iterations producing one quotient bit per cycle. On counter==31, go to DONE with the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
- Fast path, IDLE -> DONE in one cycle:
  - Divide by zero: quotient = 0xFFFFFFFF for both signed and unsigned; remainder = op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- DONE -> IDLE unconditionally. A start is never taken from DONE, so the same instruction cannot restart; the next instruction is seen in IDLE on the following cycle.
- Latency from the start cycle T:
  - Iterative operations: DONE at T+33, stall high T..T+32 (33 cycles).
  - Fast path: DONE at T+1, stall high at T only.
- kill_ex_muldiv_i has priority over everything except reset.
  - Any state goes to IDLE on the next edge with no done pulse; result is not updated.
  - kill together with valid&is_muldiv in IDLE does not start and does not stall.
  - kill in DONE: done still reads 1 this cycle; the consumer qualifies with kill.
- valid=0 or is_muldiv=0 in IDLE: no state change, stall=0.
- Operand inputs are ignored after the start cycle. Operands change during stall without effect.
- The counter wraps only through an explicit clear on start; it never free-runs.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD -> stall for 33 cycles, done at T+33, result=0xFFFFFFEB.
- MULH op1=op2=0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- DIV 20/0xFFFFFFFD -> 0xFFFFFFFA; REM -> 2. DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> done at T+1, result 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. Each stalls exactly one cycle.
- Kill: start DIV, assert kill at T+10 -> state IDLE at T+11, stall=0, no done pulse, result keeps its prior value. Kill coincident with start -> no stall.
- Reset: assert reset asynchronously mid-MUL (T+5, between clock edges) -> stall and done drop immediately, result=0. Back-to-back MUL then DIV -> second starts the cycle after the first DONE and produces its correct result.
